// File: rtl/line_mem_arbiter.sv
// line_mem_arbiter: arbitrates icache/dcache cacheline traffic onto a single burst memory port.
// Reads are issued as one command and reassembled from BEATS returning beats; write-backs are
// serialised into BEATS beats. Each transaction ends with a one-cycle response to its owner.
module line_mem_arbiter #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned BEAT_W = 64,
   parameter int unsigned BEATS  = 4,
   parameter int unsigned LINE_W = BEAT_W * BEATS
) (
   input  logic              clk,
   input  logic              rst_n,
   // icache client
   input  logic [ADDR_W-1:0] i_addr,
   input  logic              i_read,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,
   // dcache client
   input  logic [ADDR_W-1:0] d_addr,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,
   // burst memory port
   output logic [ADDR_W-1:0] bmem_addr,
   output logic              bmem_read,
   output logic              bmem_write,
   output logic [BEAT_W-1:0] bmem_wdata,
   input  logic              bmem_ready,
   input  logic [ADDR_W-1:0] bmem_raddr,
   input  logic [BEAT_W-1:0] bmem_rdata,
   input  logic              bmem_rvalid
);

   localparam int unsigned     CntW     = $clog2(BEATS);
   localparam int unsigned     OffW     = $clog2(LINE_W / 8);
   localparam logic [CntW-1:0] LastBeat = CntW'(BEATS - 1);

   typedef enum logic [2:0] {StIdle, StRdCmd, StRdWait, StWrBeat, StResp} state_e;

   state_e                        state_q, state_d;
   logic [CntW-1:0]               cnt_q;
   logic                          last_d_q;  // 1 when the dcache held the most recent grant
   logic                          client_q;  // owner of the current transaction, 1 = dcache
   logic [ADDR_W-1:0]             addr_q;
   logic [BEATS-1:0][BEAT_W-1:0]  line_q, line_fill;
   logic [LINE_W-1:0]             i_rdata_q, d_rdata_q;

   logic i_req, d_req, grant_any, grant_d_sel, grant_wr, beat_hit, last_fill;
   logic unused_offset;

   // Line offset bits are dropped when the address is aligned.
   assign unused_offset = ^{i_addr[OffW-1:0], d_addr[OffW-1:0]};

   assign i_req       = i_read;
   assign d_req       = d_read | d_write;
   assign grant_any   = i_req | d_req;
   // On contention the client that did not win last time goes first.
   assign grant_d_sel = d_req & (~i_req | ~last_d_q);
   // A dcache write-back takes precedence over a simultaneous dcache read.
   assign grant_wr    = grant_d_sel & d_write;
   // Only beats tagged with the in-flight line address count towards the fill.
   assign beat_hit    = (state_q == StRdWait) & bmem_rvalid & (bmem_raddr == addr_q);
   assign last_fill   = beat_hit & (cnt_q == LastBeat);

   assign i_rdata = i_rdata_q;
   assign d_rdata = d_rdata_q;

   // Line buffer with the current returning beat merged into its slot.
   always_comb begin
      line_fill        = line_q;
      line_fill[cnt_q] = bmem_rdata;
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (grant_any) state_d = grant_wr ? StWrBeat : StRdCmd;
         StRdCmd:  if (bmem_ready) state_d = StRdWait;
         StRdWait: if (last_fill) state_d = StResp;
         StWrBeat: if (bmem_ready && (cnt_q == LastBeat)) state_d = StResp;
         StResp:   state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // Outputs decoded from the current state.
   always_comb begin
      i_resp     = 1'b0;
      d_resp     = 1'b0;
      bmem_read  = 1'b0;
      bmem_write = 1'b0;
      bmem_addr  = '0;
      bmem_wdata = '0;
      unique case (state_q)
         StRdCmd: begin
            bmem_read = 1'b1;
            bmem_addr = addr_q;
         end
         StWrBeat: begin
            bmem_write = 1'b1;
            bmem_addr  = addr_q;
            bmem_wdata = line_q[cnt_q];
         end
         StResp: begin
            i_resp = ~client_q;
            d_resp = client_q;
         end
         default: ;
      endcase
   end

   // Transaction latch, beat counter, line assembly and per-client read-data registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         last_d_q  <= 1'b0;
         client_q  <= 1'b0;
         addr_q    <= '0;
         line_q    <= '0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (grant_any) begin
                  client_q <= grant_d_sel;
                  last_d_q <= grant_d_sel;
                  addr_q   <= grant_d_sel ? {d_addr[ADDR_W-1:OffW], OffW'(0)}
                                          : {i_addr[ADDR_W-1:OffW], OffW'(0)};
                  line_q   <= d_wdata;
               end
            end
            StRdWait: begin
               if (beat_hit) begin
                  line_q <= line_fill;
                  cnt_q  <= (cnt_q == LastBeat) ? '0 : cnt_q + 1'b1;
                  // Load the owner's output register so it is valid during the response cycle.
                  if (last_fill) begin
                     if (client_q) d_rdata_q <= line_fill;
                     else          i_rdata_q <= line_fill;
                  end
               end
            end
            StWrBeat: begin
               if (bmem_ready) cnt_q <= (cnt_q == LastBeat) ? '0 : cnt_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_line_mem_arbiter.sv
// Directed bench for line_mem_arbiter: reads, write-backs, back-pressure, contention,
// stray beats and mid-burst reset, all checked against hand-computed values.
module tb_line_mem_arbiter;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned BEAT_W = 64;
   localparam int unsigned BEATS  = 4;
   localparam int unsigned LINE_W = 256;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [ADDR_W-1:0] i_addr = '0;
   logic              i_read = 1'b0;
   logic [LINE_W-1:0] i_rdata;
   logic              i_resp;
   logic [ADDR_W-1:0] d_addr = '0;
   logic              d_read = 1'b0;
   logic              d_write = 1'b0;
   logic [LINE_W-1:0] d_wdata = '0;
   logic [LINE_W-1:0] d_rdata;
   logic              d_resp;
   logic [ADDR_W-1:0] bmem_addr;
   logic              bmem_read;
   logic              bmem_write;
   logic [BEAT_W-1:0] bmem_wdata;
   logic              bmem_ready = 1'b1;
   logic [ADDR_W-1:0] bmem_raddr = '0;
   logic [BEAT_W-1:0] bmem_rdata = '0;
   logic              bmem_rvalid = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   line_mem_arbiter #(
      .ADDR_W(ADDR_W), .BEAT_W(BEAT_W), .BEATS(BEATS), .LINE_W(LINE_W)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
      .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_resp(d_resp),
      .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
      .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
      .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_bit(input string tag, input logic obs, input logic exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk_addr(input string tag, input logic [ADDR_W-1:0] obs,
                           input logic [ADDR_W-1:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_word(input string tag, input logic [BEAT_W-1:0] obs,
                           input logic [BEAT_W-1:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_line(input string tag, input logic [LINE_W-1:0] obs,
                           input logic [LINE_W-1:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present one valid read beat for one cycle.
   task automatic feed(input logic [ADDR_W-1:0] a, input logic [BEAT_W-1:0] d);
      bmem_rvalid = 1'b1;
      bmem_raddr  = a;
      bmem_rdata  = d;
      step();
      bmem_rvalid = 1'b0;
      bmem_raddr  = '0;
      bmem_rdata  = '0;
   endtask

   // Advance until the read command appears, bounded.
   task automatic wait_rd(output logic ok);
      ok = 1'b0;
      for (int c = 0; c < 6; c++) begin
         if (bmem_read) begin
            ok = 1'b1;
            break;
         end
         step();
      end
   endtask

   logic [LINE_W-1:0] exp_i, exp_d, exp_line, wline;
   logic [BEAT_W-1:0] bt;
   logic              ok, owner_d;
   int                ke, f_hold, n_resp;

   initial begin
      // Reset state
      step();
      step();
      chk_line("rst_i_rdata", i_rdata, '0);
      chk_line("rst_d_rdata", d_rdata, '0);
      chk_bit("rst_i_resp", i_resp, 1'b0);
      chk_bit("rst_d_resp", d_resp, 1'b0);
      chk_bit("rst_bmem_read", bmem_read, 1'b0);
      chk_bit("rst_bmem_write", bmem_write, 1'b0);
      chk_addr("rst_bmem_addr", bmem_addr, '0);
      chk_word("rst_bmem_wdata", bmem_wdata, '0);
      rst_n = 1'b1;
      step();

      // Icache read of an unaligned address
      exp_i = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
               64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
      exp_d = '0;
      i_addr = 32'h0000_1234;
      i_read = 1'b1;
      step();
      chk_bit("t1_rd_cmd", bmem_read, 1'b1);
      chk_addr("t1_addr", bmem_addr, 32'h0000_1220);
      chk_bit("t1_no_write", bmem_write, 1'b0);
      step();
      chk_bit("t1_rd_one_cycle", bmem_read, 1'b0);
      feed(32'h0000_1220, 64'h1111_1111_1111_1111);
      feed(32'h0000_1220, 64'h2222_2222_2222_2222);
      feed(32'h0000_1220, 64'h3333_3333_3333_3333);
      chk_bit("t1_no_early_resp", i_resp, 1'b0);
      feed(32'h0000_1220, 64'h4444_4444_4444_4444);
      chk_bit("t1_i_resp", i_resp, 1'b1);
      chk_bit("t1_no_d_resp", d_resp, 1'b0);
      chk_line("t1_i_rdata", i_rdata, exp_i);
      i_read = 1'b0;
      step();
      chk_bit("t1_resp_pulse", i_resp, 1'b0);
      chk_line("t1_i_rdata_hold", i_rdata, exp_i);

      // Dcache write-back with memory always ready
      wline = {64'hDDDD_0000_0000_000D, 64'hCCCC_0000_0000_000C,
               64'hBBBB_0000_0000_000B, 64'hAAAA_0000_0000_000A};
      d_addr  = 32'h8000_0040;
      d_wdata = wline;
      d_write = 1'b1;
      step();
      chk_addr("t2_addr", bmem_addr, 32'h8000_0040);
      for (int k = 0; k < 4; k++) begin
         chk_bit("t2_write", bmem_write, 1'b1);
         chk_word("t2_wdata", bmem_wdata, wline[k*64 +: 64]);
         chk_bit("t2_no_read", bmem_read, 1'b0);
         step();
      end
      chk_bit("t2_d_resp", d_resp, 1'b1);
      chk_bit("t2_write_done", bmem_write, 1'b0);
      chk_line("t2_d_rdata_untouched", d_rdata, exp_d);
      d_write = 1'b0;
      step();
      chk_bit("t2_resp_pulse", d_resp, 1'b0);

      // Write-back with the second beat stalled for three cycles
      wline = {64'h0000_0000_0000_00E4, 64'h0000_0000_0000_00E3,
               64'h0000_0000_0000_00E2, 64'h0000_0000_0000_00E1};
      d_addr  = 32'h8000_0080;
      d_wdata = wline;
      d_write = 1'b1;
      ke = 0;
      f_hold = 0;
      n_resp = 0;
      for (int c = 0; c < 10; c++) begin
         step();
         bmem_ready = (c >= 1 && c <= 3) ? 1'b0 : 1'b1;
         chk_bit("t3_no_read", bmem_read, 1'b0);
         if (bmem_write && ke < 4) begin
            chk_word("t3_wdata", bmem_wdata, wline[ke*64 +: 64]);
            if (bmem_wdata == 64'h0000_0000_0000_00E2) f_hold++;
            if (bmem_ready) ke++;
         end
         if (d_resp) begin
            n_resp++;
            d_write = 1'b0;
         end
      end
      bmem_ready = 1'b1;
      chk_addr("t3_beats_accepted", 32'(ke), 32'd4);
      chk_addr("t3_beat1_held", 32'(f_hold), 32'd4);
      chk_addr("t3_single_resp", 32'(n_resp), 32'd1);

      // Contention: dcache won last, so grants go icache, dcache, icache
      i_addr = 32'h0000_2000;
      d_addr = 32'h0000_3000;
      i_read = 1'b1;
      d_read = 1'b1;
      for (int g = 0; g < 3; g++) begin
         owner_d = (g == 1);
         wait_rd(ok);
         chk_bit("t4_cmd_seen", ok, 1'b1);
         chk_addr("t4_grant_addr", bmem_addr, owner_d ? 32'h0000_3000 : 32'h0000_2000);
         step();
         for (int k = 0; k < 4; k++) begin
            bt = 64'hC0DE_0000_0000_0000 + 64'(g) * 64'h100 + 64'(k);
            exp_line[k*64 +: 64] = bt;
            feed(owner_d ? 32'h0000_3000 : 32'h0000_2000, bt);
         end
         chk_bit("t4_i_resp", i_resp, !owner_d);
         chk_bit("t4_d_resp", d_resp, owner_d);
         if (owner_d) begin
            exp_d = exp_line;
            chk_line("t4_d_rdata", d_rdata, exp_d);
            chk_line("t4_i_rdata_hold", i_rdata, exp_i);
         end else begin
            exp_i = exp_line;
            chk_line("t4_i_rdata", i_rdata, exp_i);
            chk_line("t4_d_rdata_hold", d_rdata, exp_d);
         end
         step();
      end
      i_read = 1'b0;
      d_read = 1'b0;
      step();
      chk_bit("t4_no_extra_grant", bmem_read, 1'b0);

      // Stray beats: wrong tag, and right tag without rvalid
      exp_i = {64'h0000_0000_0000_4403, 64'h0000_0000_0000_4402,
               64'h0000_0000_0000_4401, 64'h0000_0000_0000_4400};
      i_addr = 32'h0000_4000;
      i_read = 1'b1;
      wait_rd(ok);
      chk_bit("t5_cmd_seen", ok, 1'b1);
      step();
      feed(32'h0000_4000, 64'h0000_0000_0000_4400);
      feed(32'h0000_4020, 64'hDEAD_BEEF_DEAD_BEEF);
      bmem_raddr = 32'h0000_4000;
      bmem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
      step();
      feed(32'h0000_4000, 64'h0000_0000_0000_4401);
      feed(32'h0000_4000, 64'h0000_0000_0000_4402);
      chk_bit("t5_no_early_resp", i_resp, 1'b0);
      feed(32'h0000_4000, 64'h0000_0000_0000_4403);
      chk_bit("t5_i_resp", i_resp, 1'b1);
      chk_line("t5_i_rdata", i_rdata, exp_i);
      i_read = 1'b0;
      step();

      // Reset after two beats of a read, then a fresh read
      i_addr = 32'h0000_5000;
      i_read = 1'b1;
      wait_rd(ok);
      chk_bit("t6_cmd_seen", ok, 1'b1);
      step();
      feed(32'h0000_5000, 64'h5555_0000_0000_0000);
      feed(32'h0000_5000, 64'h5555_0000_0000_0001);
      rst_n = 1'b0;
      #1;
      chk_line("t6_i_rdata_cleared", i_rdata, '0);
      chk_line("t6_d_rdata_cleared", d_rdata, '0);
      chk_addr("t6_bmem_addr_cleared", bmem_addr, '0);
      i_read = 1'b0;
      step();
      step();
      chk_bit("t6_no_resp", i_resp, 1'b0);
      rst_n = 1'b1;
      step();
      exp_i = {64'h6666_0000_0000_0003, 64'h6666_0000_0000_0002,
               64'h6666_0000_0000_0001, 64'h6666_0000_0000_0000};
      i_addr = 32'h0000_6000;
      i_read = 1'b1;
      wait_rd(ok);
      chk_bit("t6_fresh_cmd_seen", ok, 1'b1);
      chk_addr("t6_fresh_addr", bmem_addr, 32'h0000_6000);
      step();
      feed(32'h0000_6000, 64'h6666_0000_0000_0000);
      feed(32'h0000_6000, 64'h6666_0000_0000_0001);
      feed(32'h0000_6000, 64'h6666_0000_0000_0002);
      chk_bit("t6_no_early_resp", i_resp, 1'b0);
      feed(32'h0000_6000, 64'h6666_0000_0000_0003);
      chk_bit("t6_i_resp", i_resp, 1'b1);
      chk_line("t6_i_rdata", i_rdata, exp_i);
      i_read = 1'b0;
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
